// File: rtl/dog_stage.sv
`default_nettype none
// ============================================================================
// Module      : dog_stage
// Description : Difference-of-Gaussians stage. Drops filter fill samples,
//               aligns fine/coarse streams and emits a signed 9-bit DoG pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module dog_stage #(
    parameter int IMG_W = 400,
    parameter int IMG_H = 300,
    parameter int FILL  = 802,
    parameter int ALIGN = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clk_en,
    input  logic       sof,
    input  logic [7:0] g_fine,
    input  logic [7:0] g_coarse,
    output logic [8:0] dog,
    output logic       dog_valid,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       eol,
    output logic       eof
);

    localparam logic [11:0] c_fill  = 12'(FILL);
    localparam logic [8:0]  c_xmax  = 9'(IMG_W - 1);
    localparam logic [8:0]  c_ymax  = 9'(IMG_H - 1);
    localparam bit          c_fill0 = (FILL == 0);
    localparam bit          c_fill1 = (FILL == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_fill_cnt;
    logic [8:0]  r_x_cnt;
    logic [8:0]  r_y_cnt;

    logic [7:0]  w_fine_al;
    logic [8:0]  w_diff;
    logic        w_emit;
    logic [8:0]  w_out_x;
    logic [8:0]  w_out_y;
    logic        w_eol;
    logic        w_eof;

    generate
        if (ALIGN == 0) begin : g_no_align
            assign w_fine_al = g_fine;
        end else begin : g_align
            logic [7:0] r_dly [ALIGN];

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int i = 0; i < ALIGN; i++) begin
                        r_dly[i] <= 8'd0;
                    end
                end else if (Clk_en) begin
                    r_dly[0] <= g_fine;
                    for (int i = 1; i < ALIGN; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_fine_al = r_dly[ALIGN-1];
        end
    endgenerate

    assign w_diff = {1'b0, w_fine_al} - {1'b0, g_coarse};

    // A sof sample is itself output only when there is nothing to fill.
    assign w_emit  = Clk_en && (sof ? c_fill0 : (r_state == S_RUN));
    assign w_out_x = sof ? 9'd0 : r_x_cnt;
    assign w_out_y = sof ? 9'd0 : r_y_cnt;
    assign w_eol   = (w_out_x == c_xmax);
    assign w_eof   = w_eol && (w_out_y == c_ymax);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_fill_cnt <= 12'd0;
            r_x_cnt    <= 9'd0;
            r_y_cnt    <= 9'd0;
            dog        <= 9'd0;
            dog_valid  <= 1'b0;
            x          <= 9'd0;
            y          <= 9'd0;
            eol        <= 1'b0;
            eof        <= 1'b0;
        end else begin
            dog_valid <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            if (Clk_en) begin
                if (w_emit) begin
                    dog       <= w_diff;
                    x         <= w_out_x;
                    y         <= w_out_y;
                    dog_valid <= 1'b1;
                    eol       <= w_eol;
                    eof       <= w_eof;
                    if (w_eol) begin
                        r_x_cnt <= 9'd0;
                        r_y_cnt <= w_eof ? 9'd0 : w_out_y + 9'd1;
                    end else begin
                        r_x_cnt <= w_out_x + 9'd1;
                        r_y_cnt <= w_out_y;
                    end
                end
                if (sof) begin
                    r_fill_cnt <= 12'd1;
                    if (!w_emit) begin
                        r_x_cnt <= 9'd0;
                        r_y_cnt <= 9'd0;
                    end
                    if (w_emit && w_eof) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= (c_fill0 || c_fill1) ? S_RUN : S_FILL;
                    end
                end else begin
                    case (r_state)
                        S_FILL: begin
                            r_fill_cnt <= r_fill_cnt + 12'd1;
                            if (r_fill_cnt + 12'd1 == c_fill) begin
                                r_state <= S_RUN;
                            end
                        end
                        S_RUN: begin
                            if (w_eof) begin
                                r_state <= S_IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire
